// File: rtl/svnet_pipe_ctrl_pkg.sv
// Shared types and constants for the svnet_pipe_ctrl valid/ready pipeline controller.
package svnet_pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    DRAINED = 2'd2
  } pipe_state_t;

  localparam int STAT_W = 32;

  // Saturating increment: holds at all-ones instead of wrapping to zero.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] val);
    if (val == {STAT_W{1'b1}}) begin
      return val;
    end else begin
      return val + STAT_W'(1);
    end
  endfunction

endpackage

// File: rtl/svnet_pipe_ctrl_stats.sv
// Output-side statistics for svnet_pipe_ctrl: saturating stall counter and wrapping
// completed-beat counter, both cleared by rst and flush.
module svnet_pipe_ctrl_stats
  import svnet_pipe_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              out_valid,
  input  logic              out_ready,
  output logic [STAT_W-1:0] stall_cycles,
  output logic [STAT_W-1:0] beats_out
);

  logic [STAT_W-1:0] stall_q, stall_d;
  logic [STAT_W-1:0] beats_q, beats_d;

  // Next-value logic; flush wins over any stall or emit in the same cycle.
  always_comb begin
    stall_d = stall_q;
    beats_d = beats_q;
    if (flush) begin
      stall_d = '0;
      beats_d = '0;
    end else begin
      if (out_valid && !out_ready) begin
        stall_d = sat_inc(stall_q);
      end else begin
        stall_d = stall_q;
      end
      if (out_valid && out_ready) begin
        beats_d = beats_q + STAT_W'(1);
      end else begin
        beats_d = beats_q;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      beats_q <= '0;
    end else begin
      stall_q <= stall_d;
      beats_q <= beats_d;
    end
  end

  assign stall_cycles = stall_q;
  assign beats_out    = beats_q;

endmodule

// File: rtl/svnet_pipe_ctrl.sv
// Valid/ready flow controller for an external DEPTH-stage datapath pipeline.
// Optional output statistics are built when SVNET_PIPE_CTRL_STATS_EN is defined.
module svnet_pipe_ctrl
  import svnet_pipe_ctrl_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DEPTH-1:0]  stage_en,
  output logic [DEPTH-1:0]  stage_valid,
  input  logic              flush,
  input  logic              drain_req,
  output logic              drained,
  output logic [CNT_W-1:0]  occupancy,
  output logic [STAT_W-1:0] stall_cycles,
  output logic [STAT_W-1:0] beats_out
);

  generate
    if (DEPTH < 1 || DEPTH > 16) begin : g_bad_depth
      $error("svnet_pipe_ctrl: DEPTH must be in the range 1..16");
    end
  endgenerate

  logic [DEPTH-1:0] v_q, v_d;
  logic [DEPTH-1:0] en_s;
  logic [CNT_W-1:0] occ_q, occ_d;
  pipe_state_t      state_q, state_d;
  logic             in_ready_s;
  logic             accept_s;
  logic             emit_s;

  // A stage may load when it, or any stage ahead of it, is empty or the consumer takes.
  always_comb begin : p_enable
    logic chain_v;
    chain_v = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      chain_v = chain_v || !v_q[i];
      en_s[i] = chain_v;
    end
  end

  assign in_ready_s = en_s[0] && (state_q == RUN) && !flush;
  assign accept_s   = in_valid && in_ready_s;
  assign emit_s     = v_q[DEPTH-1] && out_ready;

  // Valid-bit shift with hold on disabled stages; flush empties everything.
  always_comb begin
    v_d = v_q;
    if (flush) begin
      v_d = '0;
    end else begin
      for (int i = DEPTH - 1; i >= 1; i--) begin
        if (en_s[i]) begin
          v_d[i] = v_q[i-1];
        end else begin
          v_d[i] = v_q[i];
        end
      end
      if (en_s[0]) begin
        v_d[0] = accept_s;
      end else begin
        v_d[0] = v_q[0];
      end
    end
  end

  // Occupancy tracks accepts minus emits; simultaneous accept and emit cancel.
  always_comb begin
    if (flush) begin
      occ_d = '0;
    end else begin
      occ_d = occ_q + CNT_W'(accept_s) - CNT_W'(emit_s);
    end
  end

  // Drain sequencing: a dropped drain_req always returns to RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (drain_req) begin
          state_d = DRAIN;
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        if (!drain_req) begin
          state_d = RUN;
        end else if ((occ_q == '0) || flush) begin
          state_d = DRAINED;
        end else begin
          state_d = DRAIN;
        end
      end
      DRAINED: begin
        if (!drain_req) begin
          state_d = RUN;
        end else begin
          state_d = DRAINED;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q     <= '0;
      occ_q   <= '0;
      state_q <= RUN;
    end else begin
      v_q     <= v_d;
      occ_q   <= occ_d;
      state_q <= state_d;
    end
  end

  assign in_ready    = in_ready_s;
  assign out_valid   = v_q[DEPTH-1];
  assign stage_en    = en_s;
  assign stage_valid = v_q;
  assign occupancy   = occ_q;
  assign drained     = (state_q == DRAINED);

`ifdef SVNET_PIPE_CTRL_STATS_EN
  svnet_pipe_ctrl_stats u_stats (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .out_valid    (v_q[DEPTH-1]),
    .out_ready    (out_ready),
    .stall_cycles (stall_cycles),
    .beats_out    (beats_out)
  );
`else
  assign stall_cycles = '0;
  assign beats_out    = '0;
`endif

endmodule
